inst_mem_responder: RTL

//  Instruction-side responder for the pipelined RiSC-16 core: answers the core's o_pc_next

---
 rtl/risc16_pkg.sv | 30 +++
 rtl/imem_ram.sv | 33 +++
 rtl/inst_mem_responder.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/risc16_pkg.sv
// Shared RiSC-16 definitions: instruction encoding, the fetch NOP and the
// instruction-responder state encoding. Used by the core, the responder and benches.
package risc16_pkg;

    localparam int          WORD_LEN = 16;
    localparam logic [15:0] NOP_WORD = 16'h0000;  // ADD r0,r0,r0

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_ADDI = 3'd1,
        OP_NAND = 3'd2,
        OP_LUI  = 3'd3,
        OP_SW   = 3'd4,
        OP_LW   = 3'd5,
        OP_BEQ  = 3'd6,
        OP_JALR = 3'd7
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2,
        ST_RUN   = 2'd3
    } resp_state_e;

    function automatic opcode_e opcode_of(input logic [15:0] word);
        return opcode_e'(word[15:13]);
    endfunction

endpackage

// File: rtl/imem_ram.sv
// Simple dual-port instruction RAM: loader writes on one port, fetch reads on the
// other with a registered, enable-gated output so a stalled fetch keeps its word.
module imem_ram #(
    parameter int p_WORD_LEN = 16,
    parameter int p_ADDR_LEN = 10
) (
    input  logic                  i_clk,
    input  logic                  i_wr_en,
    input  logic [p_ADDR_LEN-1:0] i_wr_addr,
    input  logic [p_WORD_LEN-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [p_ADDR_LEN-1:0] i_rd_addr,
    output logic [p_WORD_LEN-1:0] o_rd_data
);

    logic [p_WORD_LEN-1:0] mem_reg [2**p_ADDR_LEN];
    logic [p_WORD_LEN-1:0] rd_data_reg;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem_reg[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rd_en) begin
            rd_data_reg <= mem_reg[i_rd_addr];
        end
    end

    assign o_rd_data = rd_data_reg;

endmodule

// File: rtl/inst_mem_responder.sv
// Instruction-side responder: loads a program from a valid/ready host stream while
// holding the core in reset, then serves fetches with one-cycle latency and stall hold.
module inst_mem_responder
    import risc16_pkg::*;
#(
    parameter int                    p_WORD_LEN = WORD_LEN,
    parameter int                    p_ADDR_LEN = 10,
    parameter logic [p_WORD_LEN-1:0] p_NOP      = p_WORD_LEN'(NOP_WORD)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [15:0]           i_pc_next,
    input  logic                  i_stall_fetch,
    output logic [p_WORD_LEN-1:0] o_inst,
    output logic                  o_core_rst,
    input  logic                  i_ld_valid,
    output logic                  o_ld_ready,
    input  logic [p_WORD_LEN-1:0] i_ld_data,
    input  logic                  i_ld_last,
    input  logic                  i_run,
    input  logic                  i_abort,
    output logic                  o_running,
    output logic [p_ADDR_LEN:0]   o_ld_count,
    output logic                  o_err_ovf,
    output logic                  o_err_oob
);

    localparam int                DEPTH     = 2**p_ADDR_LEN;
    localparam logic [p_ADDR_LEN:0] LAST_ADDR = (p_ADDR_LEN+1)'(DEPTH - 1);
    localparam logic [16:0]       DEPTH_PC  = 17'(DEPTH);

    resp_state_e             state_reg;
    logic [p_ADDR_LEN:0]     ld_count_reg;
    logic                    err_ovf_reg;
    logic                    err_oob_reg;
    logic                    core_rst_reg;
    logic                    ld_ready_reg;
    logic                    running_reg;
    logic                    nop_sel_reg;

    logic                    ld_accept;
    logic                    fetch_active;
    logic                    pc_in_range;
    logic [p_ADDR_LEN-1:0]   wr_addr;
    logic [p_WORD_LEN-1:0]   ram_rd_data;

    // An abort on the same edge as a loader handshake discards that word.
    assign ld_accept    = i_ld_valid & ld_ready_reg & ~i_abort;
    assign fetch_active = (state_reg == ST_READY) || (state_reg == ST_RUN);
    assign pc_in_range  = {1'b0, i_pc_next} < DEPTH_PC;
    assign wr_addr      = (state_reg == ST_IDLE) ? '0 : ld_count_reg[p_ADDR_LEN-1:0];

    imem_ram #(
        .p_WORD_LEN (p_WORD_LEN),
        .p_ADDR_LEN (p_ADDR_LEN)
    ) u_ram (
        .i_clk     (i_clk),
        .i_wr_en   (ld_accept),
        .i_wr_addr (wr_addr),
        .i_wr_data (i_ld_data),
        .i_rd_en   (~i_stall_fetch),
        .i_rd_addr (i_pc_next[p_ADDR_LEN-1:0]),
        .o_rd_data (ram_rd_data)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg    <= ST_IDLE;
            ld_count_reg <= '0;
            err_ovf_reg  <= 1'b0;
            err_oob_reg  <= 1'b0;
            core_rst_reg <= 1'b1;
            ld_ready_reg <= 1'b0;
            running_reg  <= 1'b0;
            nop_sel_reg  <= 1'b1;
        end else if (i_abort) begin
            state_reg    <= ST_IDLE;
            core_rst_reg <= 1'b1;
            ld_ready_reg <= 1'b1;
            running_reg  <= 1'b0;
            nop_sel_reg  <= 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    ld_ready_reg <= 1'b1;
                    if (ld_accept) begin
                        ld_count_reg <= (p_ADDR_LEN+1)'(1);
                        err_ovf_reg  <= 1'b0;
                        err_oob_reg  <= 1'b0;
                        if (i_ld_last) begin
                            state_reg    <= ST_READY;
                            ld_ready_reg <= 1'b0;
                        end else begin
                            state_reg <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (ld_accept) begin
                        ld_count_reg <= ld_count_reg + 1'b1;
                        // Writing the top word always ends the load, so the count tops out at DEPTH.
                        if (i_ld_last || ld_count_reg == LAST_ADDR) begin
                            state_reg    <= ST_READY;
                            ld_ready_reg <= 1'b0;
                            err_ovf_reg  <= ~i_ld_last;
                        end
                    end
                end
                ST_READY: begin
                    if (i_run) begin
                        state_reg    <= ST_RUN;
                        core_rst_reg <= 1'b0;
                        running_reg  <= 1'b1;
                    end
                end
                ST_RUN: begin
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase

            if (fetch_active) begin
                if (!i_stall_fetch) begin
                    nop_sel_reg <= ~pc_in_range;
                    if (!pc_in_range && state_reg == ST_RUN) begin
                        err_oob_reg <= 1'b1;
                    end
                end
            end else begin
                nop_sel_reg <= 1'b1;
            end
        end
    end

    assign o_inst     = nop_sel_reg ? p_NOP : ram_rd_data;
    assign o_core_rst = core_rst_reg;
    assign o_ld_ready = ld_ready_reg;
    assign o_running  = running_reg;
    assign o_ld_count = ld_count_reg;
    assign o_err_ovf  = err_ovf_reg;
    assign o_err_oob  = err_oob_reg;

endmodule
